// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared pipeline constants for the MIPS front end: reset PC, the NOP
// encoding used for bubbles, the jump opcode/funct values and the fetch
// state encoding.
// ---------------------------------------------------------------------------
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

    localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
    localparam logic [5:0] OPCODE_J       = 6'h02;
    localparam logic [5:0] OPCODE_JAL     = 6'h03;
    localparam logic [5:0] FUNCT_JR       = 6'h08;
    localparam logic [5:0] FUNCT_JALR     = 6'h09;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Priority: flush > hold > bubble > load.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 squash contents to a NOP bubble
//   wr_en                 0 = hold current contents
//   fetch_ready           instruction memory returned a word this cycle
//   fetch_instr           instruction word for the current PC
//   fetch_pc_plus4        PC+4 of that instruction
//   instruction, pc_plus4, valid   registered outputs
// ---------------------------------------------------------------------------
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        wr_en,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc_plus4,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_INSTR;
            pc_plus4    <= 32'd0;
            valid       <= 1'b0;
        end else if (flush || (wr_en && !fetch_ready)) begin
            // flush wins over a hold; a missing fetch word becomes a bubble
            instruction <= NOP_INSTR;
            pc_plus4    <= 32'd0;
            valid       <= 1'b0;
        end else if (wr_en) begin
            instruction <= fetch_instr;
            pc_plus4    <= fetch_pc_plus4;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: PC register, next-PC selection, instruction
// memory request and the IF/ID register.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   PC_Wr_en, IF_ID_Wr_en, IF_ID_flush   hazard unit controls
//   Branch_hazard, Branch_target     taken-branch redirect from EX
//   ID_Jump, Jump_target26           j/jal redirect from ID
//   ID_JumpReg, JumpReg_target       jr/jalr redirect from ID
//   imem_addr, imem_rdata, imem_ready    instruction memory interface
//   PC                               current fetch PC
//   IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_valid   IF/ID register
// Optional (macro IF_PERF_CNT_EN):
//   perf_fetch_cnt, perf_imem_stall_cnt, perf_redirect_cnt  saturating
//
// Fetch FSM
//   state | meaning
//   FETCH | issuing a fetch, memory answered or nothing pending
//   WAIT  | fetch outstanding, memory not ready, address held
// ---------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Wr_en,
    input  logic        IF_ID_Wr_en,
    input  logic        IF_ID_flush,
    input  logic        Branch_hazard,
    input  logic [31:0] Branch_target,
    input  logic        ID_Jump,
    input  logic [25:0] Jump_target26,
    input  logic        ID_JumpReg,
    input  logic [31:0] JumpReg_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_imem_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    logic [31:0]  pc_q;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic [31:0]  jump_target;
    logic         redirect;
    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         in_wait;

    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {IF_ID_PC_plus4[31:28], Jump_target26, 2'b00};
    assign imem_addr   = pc_q;
    assign PC          = pc_q;

    // A taken branch beats a load-use stall: the stalled instruction is
    // being squashed anyway. ID redirects ignore imem_ready and abandon
    // whatever fetch was pending.
    always_comb begin
        pc_next  = pc_q;
        redirect = 1'b0;
        if (Branch_hazard) begin
            pc_next  = word_align(Branch_target);
            redirect = 1'b1;
        end else if (!PC_Wr_en) begin
            pc_next = pc_q;
        end else if (ID_JumpReg) begin
            pc_next  = word_align(JumpReg_target);
            redirect = 1'b1;
        end else if (ID_Jump) begin
            pc_next  = jump_target;
            redirect = 1'b1;
        end else if (imem_ready) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (!redirect && PC_Wr_en && !imem_ready) state_d = WAIT;
            WAIT:  if (redirect || imem_ready)               state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        in_wait = (state_q == WAIT);
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (IF_ID_flush),
        .wr_en          (IF_ID_Wr_en),
        .fetch_ready    (imem_ready),
        .fetch_instr    (imem_rdata),
        .fetch_pc_plus4 (pc_plus4),
        .instruction    (IF_ID_Instruction),
        .pc_plus4       (IF_ID_PC_plus4),
        .valid          (IF_ID_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic ifid_load;
    assign ifid_load = !IF_ID_flush && IF_ID_Wr_en && imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt      <= 32'd0;
            perf_imem_stall_cnt <= 32'd0;
            perf_redirect_cnt   <= 32'd0;
        end else begin
            if (ifid_load) perf_fetch_cnt      <= sat_inc(perf_fetch_cnt);
            if (in_wait)   perf_imem_stall_cnt <= sat_inc(perf_imem_stall_cnt);
            if (redirect)  perf_redirect_cnt   <= sat_inc(perf_redirect_cnt);
        end
    end
`else
    // The wait flag only drives the stall counter.
    logic unused_in_wait;
    assign unused_in_wait = in_wait;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction-memory request and the IF/ID pipeline register.
- Sits directly upstream of the hazard unit and consumes its PC_Wr_en, IF_ID_Wr_en and IF_ID_flush.
- Applies redirects from EX (taken branch) and ID (j/jal/jr/jalr).
- Inserts bubbles when instruction memory is not ready.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on flush or bubble (sll $0,$0,0)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous, active-low reset
PC_Wr_en  in  1  from hazard unit; 0 = load-use stall, hold PC
IF_ID_Wr_en  in  1  from hazard unit; 0 = hold IF/ID contents
IF_ID_flush  in  1  from hazard unit; squash the IF/ID contents
Branch_hazard  in  1  taken branch resolved in EX
Branch_target  in  32  EX branch target address
ID_Jump  in  1  j/jal decoded in ID
Jump_target26  in  26  instr_index field of the ID instruction
ID_JumpReg  in  1  jr/jalr decoded in ID
JumpReg_target  in  32  forwarded rs value of the ID instruction
imem_addr  out  32  fetch address; equals PC
imem_rdata  in  32  instruction word for imem_addr
imem_ready  in  1  imem_rdata valid this cycle
PC  out  32  current fetch PC
IF_ID_Instruction  out  32  registered instruction
IF_ID_PC_plus4  out  32  registered PC+4 of that instruction
IF_ID_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-stall):
  - PC = RESET_PC, IF_ID_Instruction = NOP_INSTR, IF_ID_PC_plus4 = 0, IF_ID_valid = 0, all counters = 0.
- Release from reset: first fetch from RESET_PC on the first rising edge after rst_n goes high.
- imem_addr = PC, combinational. The address is held stable while imem_ready = 0 unless a redirect occurs. A redirect abandons the pending fetch.
- Next PC, priority high to low:
  1. Branch_hazard: PC <= Branch_target. Overrides PC_Wr_en = 0, because the load-use instruction is being squashed.
  2. PC_Wr_en = 0: hold.
  3. ID_JumpReg: PC <= JumpReg_target.
  4. ID_Jump: PC <= {IF_ID_PC_plus4[31:28], Jump_target26, 2'b00}.
  5. imem_ready = 0: hold.
  6. Otherwise PC <= PC + 4.
- ID_Jump and ID_JumpReg both high is illegal. ID_JumpReg wins.
- Redirects in rules 3 and 4 apply regardless of imem_ready.
- PC arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Low 2 bits of redirect targets are forced to 0.
- IF/ID update, priority high to low:
  1. IF_ID_flush: Instruction = NOP_INSTR, PC_plus4 = 0, valid = 0. Overrides IF_ID_Wr_en = 0.
  2. IF_ID_Wr_en = 0: hold all three registers.
  3. imem_ready = 0: bubble (NOP_INSTR, valid = 0, PC_plus4 = 0).
  4. Otherwise: Instruction = imem_rdata, PC_plus4 = PC + 4, valid = 1.
- Latency: an instruction appears in IF/ID one cycle after imem_ready is high for its address.
- Redirect penalty: branch = 2 bubbles, since the hazard unit flushes IF/ID and ID/EX. Jump = 1 bubble.
- Fetch FSM, 2 states:
  - FETCH: default state.
  - WAIT: entered when imem_ready = 0 while not stalled and not redirected. Stays while imem_ready = 0. Returns to FETCH on imem_ready = 1 or any redirect.
  - The state has no effect on outputs beyond the rules above. It feeds the stall counter.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds three output ports, each a 32-bit saturating counter cleared on reset:
  - perf_fetch_cnt: increments on each valid IF/ID load.
  - perf_imem_stall_cnt: increments on each cycle in WAIT.
  - perf_redirect_cnt: increments on each branch or jump redirect, counting 1 per cycle.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared pipeline package holds: RESET_PC default, NOP_INSTR, the J/JAL/JR/JALR opcode/funct constants, and the fetch-state enum (FETCH, WAIT).
- One natural sub-module: if_id_reg, the IF/ID register with flush/stall/bubble priority. PC and next-PC logic stay in the top.

Test Plan:
- Reset with imem_ready = 1 and sequential ROM → PC = 0, 4, 8 on consecutive edges; IF_ID_PC_plus4 = 4, 8; valid = 1 from cycle 1.
- PC = 0x10, PC_Wr_en = IF_ID_Wr_en = 0 for 1 cycle → PC stays 0x10 and IF/ID holds; next cycle PC = 0x14.
- PC = 0x20 and Branch_hazard = 1, Branch_target = 0x100, together with PC_Wr_en = 0 and IF_ID_flush = 1 → PC = 0x100, IF_ID_valid = 0, IF_ID_Instruction = 0.
- IF_ID_PC_plus4 = 0x4000_0008, ID_Jump = 1, Jump_target26 = 0x000_0040, IF_ID_flush = 1 → PC = 0x4000_0100, one bubble.
- imem_ready low 3 cycles at PC = 0x30 → PC holds 0x30, three bubbles with valid = 0 (with IF_PERF_CNT_EN, stall counter = 3); then loads 0x30's word.
- rst_n asserted mid-WAIT at PC = 0x44 → outputs reset immediately, without waiting for clk; PC = RESET_PC.
